// File: rtl/dline_bridge.sv
// dline_bridge: single-line write-back buffer between a 64-bit
// word requester and a 512-bit line port.
module dline_bridge (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         wenable,
  input  logic [63:0]  addr,
  input  logic [63:0]  wdata,
  output logic [63:0]  rdata,
  output logic         done,
  output logic         lrequest,
  output logic         lwrenable,
  output logic [63:0]  laddr,
  output logic [511:0] lwdata,
  input  logic [511:0] lrdata,
  input  logic         ldone
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  state_t r_state;

  logic         r_valid;
  logic         r_dirty;
  logic [57:0]  r_tag;
  logic [511:0] r_data;

  logic         r_we;
  logic [57:0]  r_ltag;
  logic [2:0]   r_idx;
  logic [63:0]  r_wdata;

  logic         r_done;
  logic [63:0]  r_rdata;
  logic         r_lreq;
  logic         r_lwr;
  logic [63:0]  r_laddr;
  logic [511:0] r_lwdata;

  logic         w_hit;
  logic [63:0]  w_hit_word;
  logic [63:0]  w_fill_word;
  logic [511:0] w_merged;
  logic         w_unused;

  // Byte offset within a word never selects anything.
  assign w_unused = ^addr[2:0];

  // Hit test and word selects for the three read paths.
  always_comb begin
    w_hit       = r_valid && (r_tag == addr[63:6]);
    w_hit_word  = r_data[{addr[5:3], 6'b0} +: 64];
    w_fill_word = lrdata[{r_idx, 6'b0} +: 64];
    w_merged    = r_data;
    w_merged[{r_idx, 6'b0} +: 64] = r_wdata;
  end

  // Control FSM with registered outputs and line buffer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_dirty  <= 1'b0;
      r_tag    <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_ltag   <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_lreq   <= 1'b0;
      r_lwr    <= 1'b0;
      r_laddr  <= '0;
      r_lwdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_we    <= wenable;
            r_ltag  <= addr[63:6];
            r_idx   <= addr[5:3];
            r_wdata <= wdata;
            if (w_hit) begin
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_rdata <= wenable ? 64'd0 : w_hit_word;
            end else if (r_dirty) begin
              r_state  <= S_WB;
              r_lreq   <= 1'b1;
              r_lwr    <= 1'b1;
              r_laddr  <= {r_tag, 6'b0};
              r_lwdata <= r_data;
            end else begin
              r_state <= S_FILL;
              r_lreq  <= 1'b1;
              r_lwr   <= 1'b0;
              r_laddr <= {addr[63:6], 6'b0};
            end
          end
        end
        S_WB: begin
          // Drop the request so the fill starts after a gap.
          if (ldone) begin
            r_state  <= S_FILL;
            r_dirty  <= 1'b0;
            r_lreq   <= 1'b0;
            r_lwr    <= 1'b0;
            r_laddr  <= '0;
            r_lwdata <= '0;
          end
        end
        S_FILL: begin
          if (!r_lreq) begin
            r_lreq  <= 1'b1;
            r_laddr <= {r_ltag, 6'b0};
          end else if (ldone) begin
            r_state <= S_RESP;
            r_data  <= lrdata;
            r_tag   <= r_ltag;
            r_valid <= 1'b1;
            r_lreq  <= 1'b0;
            r_laddr <= '0;
            r_done  <= 1'b1;
            r_rdata <= r_we ? 64'd0 : w_fill_word;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_rdata <= '0;
          if (r_we) begin
            r_data  <= w_merged;
            r_dirty <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign done      = r_done;
  assign rdata     = r_rdata;
  assign lrequest  = r_lreq;
  assign lwrenable = r_lwr;
  assign laddr     = r_laddr;
  assign lwdata    = r_lwdata;

endmodule

// File: doc/dline_bridge.md
DLINE_BRIDGE -- requirements
Module: dline_bridge

Interface
REQ-001 Parameters: none; line size fixed at 64 bytes (512 bits), word size fixed at 64 bits.
REQ-002 clk  in  1  core clock; all state changes on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low (0 = in reset); deassertion takes effect at the next posedge clk.
REQ-004 enable  in  1  requester access strobe; held high until done.
REQ-005 wenable  in  1  1 = store, 0 = load; sampled with enable.
REQ-006 addr  in  64  byte address; [63:6] line tag, [5:3] word index, [2:0] ignored.
REQ-007 wdata  in  64  store data; sampled with enable.
REQ-008 rdata  out  64  load data; valid only while done=1.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 lrequest  out  1  line-side request to the arbiter data port.
REQ-011 lwrenable  out  1  1 = line write-back, 0 = line fill.
REQ-012 laddr  out  64  line address, [5:0] always 0.
REQ-013 lwdata  out  512  write-back line data.
REQ-014 lrdata  in  512  fill line data; valid while ldone=1.
REQ-015 ldone  in  1  one-cycle line completion pulse.

Function
REQ-016 The block holds one line buffer with fields valid, dirty, tag[57:0] and data[511:0].
REQ-017 States: IDLE, WB, FILL, RESP.
REQ-018 IDLE, enable=0: remain in IDLE and drive all outputs to 0.
REQ-019 IDLE, enable=1: latch wenable/addr/wdata; hit = valid and tag==addr[63:6]; hit -> RESP; miss with dirty=1 -> WB; miss with dirty=0 -> FILL.
REQ-020 WB: lrequest=1, lwrenable=1, laddr={tag,6'b0}, lwdata=data, all held stable until ldone; on ldone, clear dirty and go to FILL.
REQ-021 FILL: lrequest=1, lwrenable=0, laddr={latched addr[63:6],6'b0}, held stable until ldone; on ldone, data<=lrdata, tag<=latched tag, valid<=1, then go to RESP.
REQ-022 lrequest drops to 0 in the cycle after ldone; a WB->FILL transition has at least one cycle with lrequest=0.
REQ-023 RESP: done=1 for exactly one cycle; next state is IDLE.
REQ-024 RESP load: rdata = data[64*idx +: 64], where idx = latched addr[5:3].
REQ-025 RESP store: word idx of data <= latched wdata on the RESP edge; dirty<=1; rdata=0.
REQ-026 Latency: a hit gives done in the cycle after enable is sampled; a clean miss gives done in the cycle after ldone; a dirty miss costs two line transactions.
REQ-027 enable is not sampled in RESP, so back-to-back requests are accepted at the earliest one cycle after done.
REQ-028 If enable drops mid-transaction, the transaction still completes, updates the buffer and pulses done.
REQ-029 ldone is ignored in IDLE and RESP.
REQ-030 Changes to addr/wdata after sampling have no effect.
REQ-031 A load hit never changes dirty.
REQ-032 A store miss write-allocates: fill the line, then merge the store word.

Reset
REQ-033 While reset=0, regardless of clk: state=IDLE, valid=0, dirty=0, done=0, rdata=0, lrequest=0, lwrenable=0, laddr=0, lwdata=0.
REQ-034 Reset asserted mid-WB or mid-FILL abandons the transaction immediately, and any dirty data is discarded.
REQ-035 The tag and data contents after reset are don't-care, because valid=0.

Verification
REQ-036 After reset, load addr=0x1008 -> FILL with laddr=0x1000, lwrenable=0; return lrdata with word1=0xAAAA -> done one cycle after ldone, rdata=0xAAAA.
REQ-037 Then load addr=0x1038 -> no lrequest; done in the cycle after sampling; rdata=word7 of the filled line.
REQ-038 Store addr=0x1010 wdata=0x1234 (hit) -> done with no line traffic; then load 0x1010 -> rdata=0x1234.
REQ-039 Then load addr=0x2000 (dirty miss) -> WB with laddr=0x1000 and lwdata word2=0x1234; at least one cycle with lrequest=0; then FILL with laddr=0x2000; done after the fill ldone.
REQ-040 Assert reset during FILL -> lrequest=0 immediately; a following load to the same line issues a new FILL (valid was cleared).
REQ-041 Drop enable during FILL -> done still pulses once; the block returns to IDLE; a spurious ldone arriving in IDLE is ignored.
